// File: rtl/conv_pkg.sv
// Shared definitions for the frame reader and the convolution core.
// No logic. Holds state encodings, default frame size, the byte-address shift and the FIFO entry layout.
// No flow control of its own.
package conv_pkg;

  // Frame-reader sequencing states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int DEF_IMG_WIDTH  = 32;
  localparam int DEF_IMG_HEIGHT = 32;

  // BRAM is word-organised (32-bit), so a pixel index becomes a byte address via <<2
  localparam int ADDR_SHIFT = 2;

  localparam int PIX_W = 8;

  // One 10-bit FIFO entry: {tuser, tlast, pixel}
  typedef struct packed {
    logic             tuser;
    logic             tlast;
    logic [PIX_W-1:0] pixel;
  } pix_ent_t;

  // Binarise a pixel against a threshold: full-scale white or black
  function automatic logic [PIX_W-1:0] binarize(input logic [PIX_W-1:0] pix, input int thresh);
    return (int'({24'd0, pix}) >= thresh) ? {PIX_W{1'b1}} : {PIX_W{1'b0}};
  endfunction

endpackage

// File: rtl/rd_fifo2.sv
// Two-entry synchronous FIFO for captured pixels plus frame markers.
// Latency: data written at edge k is the head from edge k onward (no bypass); count updates at the same edge.
// Backpressure: push ignored when full and pop ignored when empty; the reader never issues either.
//
// Ports: clk, rst_n (async, active-low), push/push_data, pop, head (current entry), count (0..2).
module rd_fifo2
  import conv_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  pix_ent_t   push_data,
  input  logic       pop,
  output pix_ent_t   head,
  output logic [1:0] count
);

  pix_ent_t   mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic       do_push;
  logic       do_pop;

  assign do_push = push && (count != 2'd2);
  assign do_pop  = pop  && (count != 2'd0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/bram_stream_reader.sv
// Streams one IMG_WIDTH x IMG_HEIGHT frame from a result BRAM onto an AXI-Stream-style pixel output.
// Latency: start sampled at E0 -> first read in the next cycle -> m_tvalid after E2; one pixel/cycle thereafter.
// Backpressure: reads are issued only while FIFO occupancy plus the in-flight read leaves room; m_tready stalls hold outputs.
//
// Ports: clk, rst_n (async, active-low); start (level), done, busy;
//        bram_addr/bram_en/bram_dout (1-cycle read latency, pixel in bits [7:0]);
//        m_tdata/m_tvalid/m_tready/m_tlast/m_tuser (tuser = first pixel, tlast = last pixel).
// Build option: define BIN_THRESH_EN to binarise pixels against THRESH at FIFO capture.
module bram_stream_reader
  import conv_pkg::*;
#(
  parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
  parameter int THRESH     = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             done,
  output logic             busy,
  output logic [31:0]      bram_addr,
  output logic             bram_en,
  input  logic [31:0]      bram_dout,
  output logic [PIX_W-1:0] m_tdata,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic             m_tlast,
  output logic             m_tuser
);

  localparam int N     = IMG_WIDTH * IMG_HEIGHT;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] rd_idx;
  logic             inflight;
  logic             inflight_user;
  logic             inflight_last;
  logic [1:0]       fifo_cnt;
  logic [1:0]       occupancy;
  logic             pop;
  logic             rd_issue;
  logic             last_rd;
  logic [PIX_W-1:0] cap_pix;
  pix_ent_t         cap_ent;
  pix_ent_t         head;

  // Upper BRAM bits carry no pixel data; THRESH is only consumed in the binarising build
  logic unused_bits;
  assign unused_bits = ^{bram_dout[31:PIX_W], 32'(THRESH)};

  assign m_tvalid  = (fifo_cnt != 2'd0);
  assign pop       = m_tvalid && m_tready;
  assign occupancy = fifo_cnt + {1'b0, inflight};
  assign last_rd   = (rd_idx == LAST_IDX);

  // A slot is free if occupancy < 2, or if a pop this cycle frees one before the new data lands
  assign rd_issue  = (state == ST_STREAM) &&
                     ((occupancy < 2'd2) || ((occupancy == 2'd2) && pop));

  assign bram_en   = rd_issue;
  assign bram_addr = rd_issue ? (32'(rd_idx) << ADDR_SHIFT) : 32'd0;

`ifdef BIN_THRESH_EN
  assign cap_pix = binarize(bram_dout[PIX_W-1:0], THRESH);
`else
  assign cap_pix = bram_dout[PIX_W-1:0];
`endif

  assign cap_ent = '{tuser: inflight_user, tlast: inflight_last, pixel: cap_pix};

  rd_fifo2 u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight),
    .push_data (cap_ent),
    .pop       (pop),
    .head      (head),
    .count     (fifo_cnt)
  );

  // Head markers are gated so nothing marks an empty FIFO
  assign m_tdata = head.pixel;
  assign m_tuser = m_tvalid && head.tuser;
  assign m_tlast = m_tvalid && head.tlast;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    busy      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_STREAM;
      end
      ST_STREAM: begin
        busy = 1'b1;
        if (rd_issue && last_rd) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (pop && head.tlast) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done = 1'b1;
        if (!start) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Read index and the one-deep in-flight tracker; markers ride alongside the read so
  // they line up with the data when it lands one cycle later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_idx        <= '0;
      inflight      <= 1'b0;
      inflight_user <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      if (state == ST_IDLE) begin
        rd_idx <= '0;
      end else if (rd_issue) begin
        rd_idx <= rd_idx + 1'b1;
      end
      inflight      <= rd_issue;
      inflight_user <= rd_issue && (rd_idx == '0);
      inflight_last <= rd_issue && last_rd;
    end
  end

endmodule

// File: tb/tb_bram_stream_reader.sv
// Randomised self-checking bench for bram_stream_reader on a 4x4 frame.
// Expected beats come from the frame contents: beat k carries word k's pixel, tuser on k=0, tlast on k=N-1.
// Read addresses must run 0,4,8,... and never leave more than two pixels outstanding.
module tb_bram_stream_reader;

  localparam int W = 4;
  localparam int H = 4;
  localparam int N = W * H;
  localparam int TH = 128;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        done;
  logic        busy;
  logic [31:0] bram_addr;
  logic        bram_en;
  logic [31:0] bram_dout;
  logic [7:0]  m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;
  logic        m_tuser;

  logic [31:0] mem [N];

  int n_cmp = 0;
  int n_err = 0;

  bram_stream_reader #(
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H),
    .THRESH     (TH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .done      (done),
    .busy      (busy),
    .bram_addr (bram_addr),
    .bram_en   (bram_en),
    .bram_dout (bram_dout),
    .m_tdata   (m_tdata),
    .m_tvalid  (m_tvalid),
    .m_tready  (m_tready),
    .m_tlast   (m_tlast),
    .m_tuser   (m_tuser)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read BRAM: data for a read in cycle k appears in cycle k+1
  initial bram_dout = 32'd0;
  always @(posedge clk) begin
    if (bram_en) begin
      if ((bram_addr >> 2) < N) bram_dout <= mem[bram_addr >> 2];
      else                      bram_dout <= 32'hDEAD_BEEF;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_pix(input logic [31:0] w);
`ifdef BIN_THRESH_EN
    return (w[7:0] >= 8'(TH)) ? 8'hFF : 8'h00;
`else
    return w[7:0];
`endif
  endfunction

  task automatic check_quiet();
    chk("q_done",  done,      0);
    chk("q_busy",  busy,      0);
    chk("q_en",    bram_en,   0);
    chk("q_addr",  bram_addr, 0);
    chk("q_vld",   m_tvalid,  0);
    chk("q_last",  m_tlast,   0);
    chk("q_user",  m_tuser,   0);
    chk("q_data",  m_tdata,   0);
  endtask

  // mode: 0 ready always, 1 ready toggling, 2 ready low 20 cycles then high, 3 random ready
  task automatic run_frame(input int mode, input int abort_beat, input bit hold_start);
    int beat;
    int reads;
    int cyc;
    int done_cyc;
    bit stalled;
    bit hs;
    logic [9:0] held;
    beat = 0; reads = 0; done_cyc = 0; stalled = 1'b0; held = '0;
    @(negedge clk);
    start    = 1'b1;
    m_tready = 1'b0;
    for (int c = 1; c <= 400; c++) begin
      cyc = c;
      @(negedge clk);
      if (cyc == 1) begin
        chk("busy_on", busy, 1);
        if (!hold_start) start = 1'b0;
      end
      if (done) begin
        done_cyc = cyc;
        break;
      end
      case (mode)
        0:       m_tready = 1'b1;
        1:       m_tready = ((cyc % 2) == 1);
        2:       m_tready = (cyc > 20);
        default: m_tready = 1'($urandom_range(0, 1));
      endcase
      #1;
      hs = m_tvalid && m_tready;
      if (stalled) begin
        chk("stall_vld", m_tvalid, 1);
        chk("stall_dat", {m_tuser, m_tlast, m_tdata}, held);
      end
      if (bram_en) begin
        chk("rd_addr", bram_addr, reads * 4);
        reads++;
        chk("rd_room", 32'((reads - beat - int'(hs)) <= 2), 1);
      end
      if (mode == 2 && cyc == 20) chk("stall_reads", 32'(reads <= 2), 1);
      if (hs) begin
        if (beat >= N) begin
          chk("extra_beat", beat, N - 1);
        end else begin
          chk("beat_dat",  m_tdata, exp_pix(mem[beat]));
          chk("beat_user", m_tuser, 32'(beat == 0));
          chk("beat_last", m_tlast, 32'(beat == N - 1));
          if (mode == 0) chk("beat_cyc", cyc, beat + 3);
        end
        beat++;
        if (abort_beat != 0 && beat == abort_beat) return;
      end
      stalled = m_tvalid && !m_tready;
      held    = {m_tuser, m_tlast, m_tdata};
    end
    if (done_cyc == 0) chk("timeout", 0, 1);
    chk("beats", beat, N);
    chk("reads", reads, N);
    // counts posedges from the start-sampling edge E0 through the edge entering DONE
    if (mode == 0) chk("done_cyc", done_cyc, N + 3);
    if (hold_start) begin
      repeat (5) begin
        @(negedge clk);
        chk("done_hold", done, 1);
        chk("no_refire", {busy, bram_en}, 0);
      end
      start = 1'b0;
    end
    @(negedge clk);
    chk("done_clr",  done, 0);
    chk("idle_busy", busy, 0);
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < N; i++) mem[i] = 32'(i * 16) | ($urandom() & 32'hFFFF_FF00);
  endtask

  task automatic fill_rand();
    for (int i = 0; i < N; i++) mem[i] = $urandom();
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    m_tready = 1'b0;
    for (int i = 0; i < N; i++) mem[i] = 32'd0;
    repeat (3) @(negedge clk);
    check_quiet();
    rst_n = 1'b1;

    fill_ramp();
    run_frame(0, 0, 1'b0);
    run_frame(1, 0, 1'b0);
    run_frame(2, 0, 1'b0);

    fill_rand();
    mem[0] = 32'd127;
    mem[1] = 32'd128;
    mem[2] = 32'h1FF;
    mem[3] = 32'd255;
    run_frame(3, 0, 1'b0);

    // Reset mid-frame after beat 5 is accepted
    fill_rand();
    run_frame(0, 6, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check_quiet();
    @(negedge clk);
    rst_n = 1'b1;
    fill_rand();
    run_frame(0, 0, 1'b0);

    fill_rand();
    run_frame(0, 0, 1'b1);

    for (int f = 0; f < 3; f++) begin
      fill_rand();
      run_frame(3, 0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bram_stream_reader.md
BRAM_STREAM_READER -- requirements
Module: bram_stream_reader

Interface
REQ-001 Parameter IMG_WIDTH, default 32, pixels per row.
REQ-002 Parameter IMG_HEIGHT, default 32, rows per frame; N = IMG_WIDTH*IMG_HEIGHT.
REQ-003 Parameter THRESH, default 128, binarization threshold (used only under REQ-031).
REQ-004 clk  in  1  clock; all logic on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 start  in  1  level request to stream one frame.
REQ-007 done  out  1  frame fully accepted downstream.
REQ-008 busy  out  1  high in STREAM and DRAIN.
REQ-009 bram_addr  out  32  byte address of result BRAM read port.
REQ-010 bram_en  out  1  BRAM read enable.
REQ-011 bram_dout  in  32  BRAM read data; bits [7:0] = pixel, [31:8] ignored.
REQ-012 m_tdata  out  8  output pixel.
REQ-013 m_tvalid  out  1  m_tdata valid.
REQ-014 m_tready  in  1  downstream accepts when high with m_tvalid.
REQ-015 m_tlast  out  1  marks pixel N-1.
REQ-016 m_tuser  out  1  marks pixel 0 (start of frame).

Function
REQ-017 States IDLE, STREAM, DRAIN, DONE; IDLE->STREAM on start=1.
REQ-018 STREAM->DRAIN on the cycle the read of index N-1 is issued.
REQ-019 DRAIN->DONE on the edge where m_tvalid & m_tready & m_tlast.
REQ-020 DONE->IDLE when start=0; DONE holds while start=1; done=1 only in DONE.
REQ-021 start in STREAM/DRAIN ignored; no restart until IDLE reached.
REQ-022 Read index i runs 0..N-1 in raster order; bram_addr = {i, 2'b00}; bram_addr combinational from index, 0 when bram_en=0.
REQ-023 BRAM read latency 1 cycle: data for a read issued in cycle k is on bram_dout in cycle k+1 and captured into a 2-entry FIFO at the end of cycle k+1.
REQ-024 A read is issued (bram_en=1) in STREAM only when FIFO count + in-flight < 2, or == 2 with a pop in the same cycle; FIFO never overflows.
REQ-025 m_tvalid = FIFO non-empty; m_tdata = FIFO head; pop on m_tvalid & m_tready.
REQ-026 m_tdata, m_tuser, m_tlast stable while m_tvalid=1 and m_tready=0; m_tvalid never drops without a handshake.
REQ-027 Latency: start sampled at edge E0 -> first bram_en in the cycle after E0 -> m_tvalid=1 after E2.
REQ-028 Throughput with m_tready held 1: one pixel per cycle; frame completes N+3 cycles after E0.
REQ-029 m_tuser=1 only on beat 0, m_tlast=1 only on beat N-1 (N=1: both on the same beat).

Reset
REQ-030 rst_n=0 at any time, including mid-frame: state IDLE, index 0, FIFO and in-flight flag cleared; done, busy, bram_en, m_tvalid, m_tlast, m_tuser = 0; bram_addr, m_tdata = 0; first frame after release starts at index 0.

Configuration
REQ-031 With BIN_THRESH_EN defined: m_tdata = (pixel >= THRESH) ? 8'd255 : 8'd0, applied at FIFO capture; latency unchanged.
REQ-032 Without BIN_THRESH_EN: m_tdata = bram_dout[7:0] unmodified; THRESH unused.

Structure
REQ-033 Shared package conv_pkg holds state encodings, default IMG_WIDTH/IMG_HEIGHT, and the byte-address shift constant (2), shared with the convolution core.
REQ-034 One sub-module rd_fifo2: 2-entry synchronous FIFO, 10-bit entries {tuser, tlast, pixel}, with count output.

Verification
REQ-035 4x4 frame, BRAM word i = i*16, m_tready=1 -> 16 beats 0,16,...,240 on consecutive cycles; tuser on beat 0, tlast on beat 15; done 19 cycles after start edge.
REQ-036 Same frame, m_tready toggling 1,0,1,0 -> identical data sequence; tdata stable during stalls; no duplicate or missing beats; bram_en never issues past FIFO capacity.
REQ-037 m_tready=0 for 20 cycles after start -> at most 2 reads issued; on release, beats resume in order from value 0.
REQ-038 rst_n pulsed low after beat 5 -> all outputs 0 immediately; next start streams from address 0 with tuser on first beat.
REQ-039 BIN_THRESH_EN, THRESH=128, words 127,128,0x1FF,255 -> tdata 0,255,255,255.
REQ-040 start held high through DONE -> done stays 1, no second frame; start low -> IDLE next cycle, done 0.
